// File: rtl/game_pkg.sv
// Shared widths, ASCII bounds and FSM encoding for the typing-game letter datapath.
package game_pkg;

    localparam int unsigned CH_W  = 8;
    localparam int unsigned X_W   = 9;
    localparam int unsigned Y_W   = 10;
    localparam int unsigned SPD_W = 3;

    localparam logic [CH_W-1:0] ASCII_A = 8'd65;
    localparam logic [CH_W-1:0] ASCII_Z = 8'd90;

    // Row at or beyond which a letter is lost; the renderer clips at the same row.
    localparam logic [X_W-1:0] X_BOTTOM_DEF = 9'd470;

    typedef enum logic [2:0] {
        StIdle,
        StMove,
        StSpawn,
        StScan,
        StResolve
    } pool_state_e;

endpackage

// File: rtl/pool_free_finder.sv
// Priority encoder: lowest-index free slot plus an any-free flag.
module pool_free_finder
    import game_pkg::*;
#(
    parameter int unsigned SLOTS = 8,
    parameter int unsigned IDX_W = $clog2(SLOTS)
) (
    input  logic [SLOTS-1:0] valid,
    output logic [IDX_W-1:0] free_idx,
    output logic             any_free
);

    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        // Walk downwards so the lowest free index is the last one written.
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                any_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/letter_pool.sv
// Pool of falling letters: spawns, moves, and removes letters on keystroke hit or bottom miss.
module letter_pool
    import game_pkg::*;
#(
    parameter int unsigned     SLOTS        = 8,
    parameter int unsigned     SPAWN_PERIOD = 60,
    parameter logic [X_W-1:0]  X_BOTTOM     = X_BOTTOM_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_tick,
    input  logic [CH_W-1:0]       gen_ch,
    input  logic [SPD_W-1:0]      gen_speed,
    input  logic [X_W-1:0]        gen_x,
    input  logic [Y_W-1:0]        gen_y,
    input  logic                  key_valid,
    input  logic [CH_W-1:0]       key_ch,
    output logic [SLOTS-1:0]      slot_valid,
    output logic [CH_W*SLOTS-1:0] slot_ch,
    output logic [X_W*SLOTS-1:0]  slot_x,
    output logic [Y_W*SLOTS-1:0]  slot_y,
    output logic [15:0]           score,
    output logic [7:0]            misses,
    output logic                  hit_pulse,
    output logic                  miss_pulse,
    output logic                  busy
);

    localparam int unsigned      IDX_W      = $clog2(SLOTS);
    localparam int unsigned      CNT_W      = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(SLOTS - 1);
    localparam logic [CNT_W-1:0] SPAWN_LAST = CNT_W'(SPAWN_PERIOD - 1);

    pool_state_e state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic            frame_pend_q, frame_pend_d;
    logic            key_pend_q, key_pend_d;
    logic [CH_W-1:0] key_hold_q, key_hold_d;
    logic [CH_W-1:0] scan_key_q, scan_key_d;
    logic            frame_start, key_start;

    logic [SLOTS-1:0] valid_q, valid_d;
    logic [CH_W-1:0]  ch_q  [SLOTS];
    logic [CH_W-1:0]  ch_d  [SLOTS];
    logic [X_W-1:0]   x_q   [SLOTS];
    logic [X_W-1:0]   x_d   [SLOTS];
    logic [Y_W-1:0]   y_q   [SLOTS];
    logic [Y_W-1:0]   y_d   [SLOTS];
    logic [SPD_W-1:0] spd_q [SLOTS];
    logic [SPD_W-1:0] spd_d [SLOTS];

    logic [CNT_W-1:0] spawn_cnt_q, spawn_cnt_d;
    logic             best_found_q, best_found_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;
    logic [X_W-1:0]   best_x_q, best_x_d;
    logic [15:0]      score_q, score_d;
    logic [7:0]       misses_q, misses_d;
    logic             hit_q, hit_d;
    logic             miss_q, miss_d;

    logic [X_W:0]     cur_nx;
    logic             cur_match;
    logic [IDX_W-1:0] free_idx;
    logic             any_free;

    pool_free_finder #(
        .SLOTS (SLOTS),
        .IDX_W (IDX_W)
    ) u_free_finder (
        .valid    (valid_q),
        .free_idx (free_idx),
        .any_free (any_free)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (frame_pend_q) begin
                    state_d = StMove;
                    idx_d   = '0;
                end else if (key_pend_q) begin
                    state_d = StScan;
                    idx_d   = '0;
                end
            end
            StMove: begin
                if (idx_q == LAST_IDX) state_d = StSpawn;
                else                   idx_d   = idx_q + 1'b1;
            end
            StSpawn: state_d = StIdle;
            StScan: begin
                if (idx_q == LAST_IDX) state_d = StResolve;
                else                   idx_d   = idx_q + 1'b1;
            end
            StResolve: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy        = (state_q != StIdle);
        frame_start = (state_q == StIdle) && frame_pend_q;
        key_start   = (state_q == StIdle) && !frame_pend_q && key_pend_q;
    end

    // A held key is never overwritten; scan_key freezes it so the latch can re-arm mid-scan.
    always_comb begin
        frame_pend_d = (frame_pend_q && !frame_start) || frame_tick;
        key_pend_d   = key_pend_q ? !key_start : key_valid;
        key_hold_d   = (key_valid && !key_pend_q) ? key_ch : key_hold_q;
        scan_key_d   = key_start ? key_hold_q : scan_key_q;
    end

    always_comb begin
        cur_nx    = {1'b0, x_q[idx_q]} + (X_W + 1)'(spd_q[idx_q]);
        cur_match = valid_q[idx_q] && (ch_q[idx_q] == scan_key_q);
    end

    always_comb begin
        valid_d      = valid_q;
        ch_d         = ch_q;
        x_d          = x_q;
        y_d          = y_q;
        spd_d        = spd_q;
        spawn_cnt_d  = spawn_cnt_q;
        best_found_d = best_found_q;
        best_idx_d   = best_idx_q;
        best_x_d     = best_x_q;
        score_d      = score_q;
        misses_d     = misses_q;
        hit_d        = 1'b0;
        miss_d       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (key_start) begin
                    best_found_d = 1'b0;
                    best_idx_d   = '0;
                    best_x_d     = '0;
                end
            end
            StMove: begin
                if (valid_q[idx_q]) begin
                    if (cur_nx >= {1'b0, X_BOTTOM}) begin
                        valid_d[idx_q] = 1'b0;
                        miss_d         = 1'b1;
                        if (misses_q != 8'hFF) misses_d = misses_q + 1'b1;
                    end else begin
                        x_d[idx_q] = cur_nx[X_W-1:0];
                    end
                end
            end
            StSpawn: begin
                if (spawn_cnt_q == SPAWN_LAST) begin
                    spawn_cnt_d = '0;
                    if (any_free) begin
                        valid_d[free_idx] = 1'b1;
                        ch_d[free_idx]    = gen_ch;
                        spd_d[free_idx]   = gen_speed;
                        x_d[free_idx]     = gen_x;
                        y_d[free_idx]     = gen_y;
                    end
                end else begin
                    spawn_cnt_d = spawn_cnt_q + 1'b1;
                end
            end
            StScan: begin
                // Strict compare: on equal rows the earlier (lower) index is kept.
                if (cur_match && (!best_found_q || (x_q[idx_q] > best_x_q))) begin
                    best_found_d = 1'b1;
                    best_idx_d   = idx_q;
                    best_x_d     = x_q[idx_q];
                end
            end
            StResolve: begin
                if (best_found_q) begin
                    valid_d[best_idx_q] = 1'b0;
                    hit_d               = 1'b1;
                    if (score_q != 16'hFFFF) score_d = score_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_pend_q <= 1'b0;
            key_pend_q   <= 1'b0;
            key_hold_q   <= '0;
            scan_key_q   <= '0;
            valid_q      <= '0;
            ch_q         <= '{default: '0};
            x_q          <= '{default: '0};
            y_q          <= '{default: '0};
            spd_q        <= '{default: '0};
            spawn_cnt_q  <= '0;
            best_found_q <= 1'b0;
            best_idx_q   <= '0;
            best_x_q     <= '0;
            score_q      <= '0;
            misses_q     <= '0;
            hit_q        <= 1'b0;
            miss_q       <= 1'b0;
        end else begin
            frame_pend_q <= frame_pend_d;
            key_pend_q   <= key_pend_d;
            key_hold_q   <= key_hold_d;
            scan_key_q   <= scan_key_d;
            valid_q      <= valid_d;
            ch_q         <= ch_d;
            x_q          <= x_d;
            y_q          <= y_d;
            spd_q        <= spd_d;
            spawn_cnt_q  <= spawn_cnt_d;
            best_found_q <= best_found_d;
            best_idx_q   <= best_idx_d;
            best_x_q     <= best_x_d;
            score_q      <= score_d;
            misses_q     <= misses_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
        end
    end

    always_comb begin
        slot_ch = '0;
        slot_x  = '0;
        slot_y  = '0;
        for (int i = 0; i < SLOTS; i++) begin
            slot_ch[i*CH_W +: CH_W] = ch_q[i];
            slot_x[i*X_W +: X_W]    = x_q[i];
            slot_y[i*Y_W +: Y_W]    = y_q[i];
        end
    end

    assign slot_valid = valid_q;
    assign score      = score_q;
    assign misses     = misses_q;
    assign hit_pulse  = hit_q;
    assign miss_pulse = miss_q;

endmodule

// File: tb/tb_letter_pool.sv
// Directed bench for letter_pool: spawn/move, miss, hit priority, full pool, ordering, reset, saturation.
module tb_letter_pool;

    localparam int unsigned SLOTS = 8;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                frame_tick = 1'b0;
    logic [7:0]          gen_ch = '0;
    logic [2:0]          gen_speed = '0;
    logic [8:0]          gen_x = '0;
    logic [9:0]          gen_y = '0;
    logic                key_valid = 1'b0;
    logic [7:0]          key_ch = '0;
    logic [SLOTS-1:0]    slot_valid;
    logic [8*SLOTS-1:0]  slot_ch;
    logic [9*SLOTS-1:0]  slot_x;
    logic [10*SLOTS-1:0] slot_y;
    logic [15:0]         score;
    logic [7:0]          misses;
    logic                hit_pulse;
    logic                miss_pulse;
    logic                busy;

    int checks = 0;
    int failures = 0;
    int hit_cnt = 0;
    int miss_cnt = 0;
    int both_cnt = 0;
    int h0;
    int m0;
    int busy_cycles;

    always #5 clk = ~clk;

    letter_pool #(
        .SLOTS        (SLOTS),
        .SPAWN_PERIOD (1),
        .X_BOTTOM     (9'd470)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .gen_ch     (gen_ch),
        .gen_speed  (gen_speed),
        .gen_x      (gen_x),
        .gen_y      (gen_y),
        .key_valid  (key_valid),
        .key_ch     (key_ch),
        .slot_valid (slot_valid),
        .slot_ch    (slot_ch),
        .slot_x     (slot_x),
        .slot_y     (slot_y),
        .score      (score),
        .misses     (misses),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse),
        .busy       (busy)
    );

    always @(negedge clk) begin
        if (hit_pulse) hit_cnt <= hit_cnt + 1;
        if (miss_pulse) miss_cnt <= miss_cnt + 1;
        if (hit_pulse && miss_pulse) both_cnt <= both_cnt + 1;
    end

    function automatic logic [7:0] ch_of(input int i);
        return slot_ch[i*8 +: 8];
    endfunction

    function automatic logic [8:0] x_of(input int i);
        return slot_x[i*9 +: 9];
    endfunction

    function automatic logic [9:0] y_of(input int i);
        return slot_y[i*10 +: 10];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input string tag);
        int   n = 0;
        logic seen = 1'b0;
        while (n < 100 && !(seen && !busy)) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
            n++;
        end
        if (n >= 100) check({tag, "_timeout"}, 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic set_gen(input logic [7:0] c, input logic [2:0] s, input logic [8:0] x,
                           input logic [9:0] y);
        gen_ch    = c;
        gen_speed = s;
        gen_x     = x;
        gen_y     = y;
    endtask

    task automatic frame();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        wait_done("frame");
    endtask

    task automatic key(input logic [7:0] c);
        @(negedge clk);
        key_valid = 1'b1;
        key_ch    = c;
        @(negedge clk);
        key_valid = 1'b0;
        wait_done("key");
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        check("rst_valid", 32'(slot_valid), 32'h0);
        check("rst_score", 32'(score), 32'h0);
        check("rst_misses", 32'(misses), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Spawn into slot 0, then move by speed on the next frame
        set_gen(8'd65, 3'd2, 9'd0, 10'd90);
        frame();
        check("spawn_valid", 32'(slot_valid), 32'h01);
        check("spawn_ch", 32'(ch_of(0)), 32'd65);
        check("spawn_x", 32'(x_of(0)), 32'd0);
        check("spawn_y", 32'(y_of(0)), 32'd90);
        set_gen(8'd66, 3'd1, 9'd0, 10'd9);
        frame();
        check("move_x", 32'(x_of(0)), 32'd2);
        check("spawn2_valid", 32'(slot_valid), 32'h03);
        check("spawn2_ch", 32'(ch_of(1)), 32'd66);

        // Bottom miss: 468 + 3 >= 470, freed slot 0 then refilled
        do_reset();
        m0 = miss_cnt;
        set_gen(8'd65, 3'd3, 9'd468, 10'd0);
        frame();
        check("miss_pre_x", 32'(x_of(0)), 32'd468);
        set_gen(8'd90, 3'd1, 9'd0, 10'd0);
        frame();
        check("miss_pulses", 32'(miss_cnt - m0), 32'd1);
        check("miss_count", 32'(misses), 32'd1);
        check("miss_score", 32'(score), 32'd0);
        check("miss_respawn_ch", 32'(ch_of(0)), 32'd90);
        check("miss_valid", 32'(slot_valid), 32'h01);

        // Two 'K's: the lower one on screen (larger x) goes first
        do_reset();
        h0 = hit_cnt;
        set_gen(8'd67, 3'd1, 9'd0, 10'd0);
        frame();
        frame();
        set_gen(8'd75, 3'd1, 9'd97, 10'd0);
        frame();
        set_gen(8'd67, 3'd1, 9'd0, 10'd0);
        frame();
        frame();
        set_gen(8'd75, 3'd1, 9'd240, 10'd0);
        frame();
        check("k_slot2_x", 32'(x_of(2)), 32'd100);
        check("k_valid0", 32'(slot_valid), 32'h3F);
        key(8'd75);
        check("k_valid1", 32'(slot_valid), 32'h1F);
        check("k_score1", 32'(score), 32'd1);
        key(8'd75);
        check("k_valid2", 32'(slot_valid), 32'h1B);
        check("k_score2", 32'(score), 32'd2);
        check("k_hits", 32'(hit_cnt - h0), 32'd2);

        // Full pool: spawn is dropped, unmatched key is harmless
        do_reset();
        set_gen(8'd67, 3'd1, 9'd0, 10'd0);
        repeat (8) frame();
        check("full_valid", 32'(slot_valid), 32'hFF);
        check("full_x0", 32'(x_of(0)), 32'd7);
        set_gen(8'd90, 3'd1, 9'd0, 10'd0);
        frame();
        check("drop_valid", 32'(slot_valid), 32'hFF);
        check("drop_ch7", 32'(ch_of(7)), 32'd67);
        check("drop_x7", 32'(x_of(7)), 32'd1);
        h0 = hit_cnt;
        key(8'd81);
        check("nomatch_hits", 32'(hit_cnt - h0), 32'd0);
        check("nomatch_score", 32'(score), 32'd0);
        check("nomatch_valid", 32'(slot_valid), 32'hFF);
        key(8'd67);
        check("c_hit_valid", 32'(slot_valid), 32'hFE);
        check("c_hit_score", 32'(score), 32'd1);

        // Frame and key together: the frame spawns the 'Z' the key then hits; mid-sweep key dropped
        h0 = hit_cnt;
        busy_cycles = 0;
        @(negedge clk);
        frame_tick = 1'b1;
        key_valid  = 1'b1;
        key_ch     = 8'd90;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) begin
                frame_tick = 1'b0;
                key_valid  = 1'b0;
            end
            if (i == 1) begin
                key_valid = 1'b1;
                key_ch    = 8'd67;
            end
            if (i == 2) key_valid = 1'b0;
            if (busy) busy_cycles++;
        end
        check("sim_busy_cycles", 32'(busy_cycles), 32'd18);
        check("sim_hits", 32'(hit_cnt - h0), 32'd1);
        check("sim_valid", 32'(slot_valid), 32'hFE);
        check("sim_score", 32'(score), 32'd2);

        // Reset on the 3rd MOVE cycle
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(slot_valid), 32'h0);
        check("mid_rst_score", 32'(score), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_pulses", 32'({hit_pulse, miss_pulse}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        set_gen(8'd65, 3'd1, 9'd0, 10'd0);
        frame();
        check("post_rst_valid", 32'(slot_valid), 32'h01);
        check("post_rst_ch", 32'(ch_of(0)), 32'd65);

        // Saturation of score and misses
        set_gen(8'd77, 3'd3, 9'd469, 10'd18);
        force dut.score_q = 16'hFFFF;
        force dut.misses_q = 8'hFF;
        frame();
        release dut.score_q;
        release dut.misses_q;
        check("sat_x1", 32'(x_of(1)), 32'd469);
        h0 = hit_cnt;
        key(8'd65);
        check("sat_score", 32'(score), 32'hFFFF);
        check("sat_hits", 32'(hit_cnt - h0), 32'd1);
        check("sat_hit_valid", 32'(slot_valid), 32'h02);
        m0 = miss_cnt;
        set_gen(8'd78, 3'd1, 9'd0, 10'd0);
        frame();
        check("sat_misses", 32'(misses), 32'hFF);
        check("sat_miss_pulses", 32'(miss_cnt - m0), 32'd1);
        check("sat_miss_valid", 32'(slot_valid), 32'h01);

        check("pulse_overlap", 32'(both_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
